aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
Iterative AES key schedule that feeds the decipher core's RoundKeys bus. It takes a cipher key and generates one 32-bit schedule word per clock. It packs all Nr+1 round keys into a flat bus in decryption order and raises valid when the whole schedule is stable. It sits directly upstream of the decipher core, which reads round_keys only while valid is high.

Parameters:
Nk, 4, key length in 32-bit words; legal values are 4, 6 and 8 (AES-128/192/256).
Nr, Nk+6, number of rounds; derived, must not be overridden independently.
NW, 4*(Nr+1), total schedule words; derived.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; latches key and begins expansion.
key  input  32*Nk  cipher key; FIPS-197 first byte is in the MSBs.
round_keys  output  128*(Nr+1)  packed schedule in decryption order; width matches the decipher RoundKeys port.
busy  output  1  high while expansion is in progress.
valid  output  1  high while round_keys holds a complete schedule for the last latched key.

Behaviour:
- One clock and an asynchronous active-low reset are fixed: the clock is clk, the reset is rst_n, and reset is asserted asynchronously, active-low.
- Reset (rst_n=0): state=IDLE, busy=0, valid=0, round_keys=0, word index=0, rcon=8'h01. Reset takes effect immediately, including mid-expansion; the partial schedule is discarded.
- State machine: IDLE, EXPAND, DONE.
  - IDLE/DONE with start=1: load w[0..Nk-1] from key (w[0] = key[32*Nk-1 -: 32]), set i=Nk, rcon=01, busy=1, valid=0, then go to EXPAND.
  - EXPAND: each cycle compute w[i] = w[i-Nk] ^ temp and store it, then i++.
  - temp is w[i-1], with these substitutions:
    - if i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, and rcon advances by xtime (0x80 -> 0x1b).
    - if Nk==8 and i mod 8 == 4: temp = SubWord(w[i-1]).
  - After writing w[NW-1]: busy=0, valid=1, go to DONE.
- Latency: start sampled at edge 0; the last word is written at edge NW-Nk; valid=1 is visible immediately after that edge. This is 40 cycles for Nk=4, 46 for Nk=6 and 52 for Nk=8.
- start while busy=1 is ignored; the key input is not re-sampled.
- start in DONE restarts expansion. valid drops on the same edge, and round_keys is not guaranteed stable until valid returns.
- key changes outside a start pulse have no effect.
- Packing: round key r is {w[4r],w[4r+1],w[4r+2],w[4r+3]}, with w[4r] in the MSBs. It is placed at slot Nr-r, i.e. round_keys[128*(Nr-r) +: 128]. So slot 0 is the final encryption round key (the decipher core's first AddRoundKey) and the top slot is the raw-key round 0.
- Slot writes happen as words complete. Slots are undefined for consumers while valid=0.
- SubWord uses four instances of the codebase's forward S-box (combinational, byte-wise); RotWord is a left byte rotate.
- Word storage is a NW x 32 register array or the packed output register itself. No RAM inference.
- Index counter width is clog2(NW)+1; there is no wrap, because the FSM leaves EXPAND at NW-1.

Test Plan:
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, pulse start -> valid rises exactly 40 cycles later; round_keys[127:0]=d014f9a8c9ee2589e13f0cc8b6630ca6; top slot equals the key.
- Nk=4, key 000102030405060708090a0b0c0d0e0f -> slot 0 = 13111d7fe3944a17f307a78b4d2b30c5; then run the decipher core on 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
- Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> after 46 cycles, slot 0 = e98ba06f448c773c8ecc720401002202.
- Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> after 52 cycles, slot 0 = fe4890d1e6188d0b046df344706c631e (checks the i mod 8 == 4 SubWord path).
- Pulse start again at cycle 10 of an expansion -> ignored; the result and timing are unchanged. Then pulse start in DONE with a new key -> valid drops next edge and returns after the full latency with the new schedule.
- Drop rst_n mid-EXPAND (cycle 20) -> busy=0, valid=0 and round_keys=0 immediately, without a clock edge. A subsequent start produces the correct schedule.

Source files
------------

// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if: start/key request and packed round-key schedule for the key expander.
interface aes_key_expander_if #(parameter int Nk = 4);
    localparam int Nr = Nk + 6;
    logic start;
    logic [32*Nk-1:0] key;
    logic [128*(Nr+1)-1:0] round_keys;
    logic busy;
    logic valid;
    modport master(output start, key, input round_keys, busy, valid);
    modport slave(input start, key, output round_keys, busy, valid);
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES key schedule, one word per clock, packed in decryption order.
module aes_key_expander #(parameter int Nk = 4) (
    input logic clk,
    input logic rst_n,
    aes_key_expander_if.slave bus
);
    localparam int Nr = Nk + 6;
    localparam int NW = 4 * (Nr + 1);
    localparam int AW = $clog2(NW);
    localparam int IW = AW + 1;
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] i, im;
    logic [7:0] rcon;
    // w[0] sits in the MSBs, so the packed words are already in decryption slot order.
    logic [0:NW-1][31:0] w;
    logic [31:0] prev, back, sub_in, sub_out, temp;
    logic wrap, half, last, load;
    assign prev = w[AW'(i - IW'(1))];
    assign back = w[AW'(i - IW'(Nk))];
    assign im = i % IW'(Nk);
    assign wrap = im == '0;
    assign half = Nk == 8 && im == IW'(4);
    assign last = i == IW'(NW - 1);
    assign load = state != EXPAND && bus.start;
    assign sub_in = wrap ? {prev[23:0], prev[31:24]} : prev;
    assign sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
    assign temp = wrap ? sub_out ^ {rcon, 24'h0} : half ? sub_out : prev;
    assign bus.round_keys = w;
    assign bus.busy = state == EXPAND;
    assign bus.valid = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        state_n = load ? EXPAND : (state == EXPAND && last) ? DONE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w <= '0;
            i <= '0;
            rcon <= 8'h01;
        end else if (load) begin
            w[0:Nk-1] <= bus.key;
            i <= IW'(Nk);
            rcon <= 8'h01;
        end else if (state == EXPAND) begin
            w[AW'(i)] <= back ^ temp;
            i <= i + IW'(1);
            if (wrap) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed FIPS-197 key schedule vectors for Nk = 4, 6 and 8.
module tb_aes_key_expander;
    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int failures = 0;
    int n;
    localparam logic [255:0] KA = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KB = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K6 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    always #5 clk = ~clk;
    aes_key_expander_if #(.Nk(4)) b4();
    aes_key_expander_if #(.Nk(6)) b6();
    aes_key_expander_if #(.Nk(8)) b8();
    aes_key_expander #(.Nk(4)) d4(.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    aes_key_expander #(.Nk(6)) d6(.clk(clk), .rst_n(rst_n), .bus(b6.slave));
    aes_key_expander #(.Nk(8)) d8(.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic pulse(input int sel, input logic [255:0] k);
        @(negedge clk);
        if (sel == 4) begin b4.start = 1; b4.key = k[127:0]; end
        else if (sel == 6) begin b6.start = 1; b6.key = k[191:0]; end
        else begin b8.start = 1; b8.key = k; end
        @(posedge clk);
        #1;
        b4.start = 0;
        b6.start = 0;
        b8.start = 0;
    endtask
    task automatic wait_valid(input int sel, output int cnt);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            cnt++;
            if ((sel == 4) ? b4.valid : (sel == 6) ? b6.valid : b8.valid) break;
        end
    endtask
    initial begin
        b4.start = 0; b4.key = '0;
        b6.start = 0; b6.key = '0;
        b8.start = 0; b8.key = '0;
        #12;
        check("rst_busy", 128'(b4.busy), 0);
        check("rst_valid", 128'(b4.valid), 0);
        check("rst_rk", 128'(|b4.round_keys), 0);
        @(negedge clk);
        rst_n = 1;
        pulse(4, KA);
        check("a_busy", 128'(b4.busy), 1);
        wait_valid(4, n);
        check("a_lat", 128'(n), 40);
        check("a_slot0", b4.round_keys[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("a_slot9", b4.round_keys[128*9 +: 128], 128'ha0fafe1788542cb123a339392a6c7605);
        check("a_top", b4.round_keys[128*10 +: 128], KA[127:0]);
        check("a_done_busy", 128'(b4.busy), 0);
        pulse(4, KB);
        check("b_valid_drop", 128'(b4.valid), 0);
        check("b_busy", 128'(b4.busy), 1);
        wait_valid(4, n);
        check("b_lat", 128'(n), 40);
        check("b_slot0", b4.round_keys[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("b_slot9", b4.round_keys[128*9 +: 128], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        pulse(6, K6);
        wait_valid(6, n);
        check("k6_lat", 128'(n), 46);
        check("k6_slot0", b6.round_keys[127:0], 128'he98ba06f448c773c8ecc720401002202);
        check("k6_top", b6.round_keys[128*12 +: 128], K6[191:64]);
        pulse(8, K8);
        wait_valid(8, n);
        check("k8_lat", 128'(n), 52);
        check("k8_slot0", b8.round_keys[127:0], 128'hfe4890d1e6188d0b046df344706c631e);
        check("k8_top", b8.round_keys[128*14 +: 128], K8[255:128]);
        pulse(4, KA);
        repeat (9) @(posedge clk);
        pulse(4, KB);
        wait_valid(4, n);
        check("ign_lat", 128'(n + 10), 40);
        check("ign_slot0", b4.round_keys[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        pulse(4, KA);
        repeat (19) @(posedge clk);
        #3;
        check("mid_busy", 128'(b4.busy), 1);
        rst_n = 0;
        #1;
        check("arst_busy", 128'(b4.busy), 0);
        check("arst_valid", 128'(b4.valid), 0);
        check("arst_rk", 128'(|b4.round_keys), 0);
        #2;
        rst_n = 1;
        pulse(4, KB);
        wait_valid(4, n);
        check("post_lat", 128'(n), 40);
        check("post_slot0", b4.round_keys[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
